// File: rtl/sad_search_pkg.sv
`default_nettype none
// ============================================================================
// Package : sad_search_pkg
// Brief   : Shared types and helpers for the SAD best-match search.
// Rev     : 1.0  initial release
// ============================================================================
package sad_search_pkg;

   localparam int SAD_W_DEF = 12;
   localparam int MV_W_DEF  = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef logic signed [MV_W_DEF-1:0] mv_t;

   function automatic int window_size(input int range);
      return (2 * range + 1) * (2 * range + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mv_raster_counter.sv
`default_nettype none
// ============================================================================
// Module : mv_raster_counter
// Brief  : Raster-order (mv_x fastest) displacement counter over +/-RANGE.
// Rev    : 1.0  initial release
// ============================================================================
module mv_raster_counter
   import sad_search_pkg::*;
#(
   parameter int RANGE = 4,
   parameter int MV_W  = MV_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   init,
   input  logic                   step,
   output logic signed [MV_W-1:0] mv_x,
   output logic signed [MV_W-1:0] mv_y,
   output logic                   last
);

   localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-RANGE);
   localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(RANGE);
   localparam logic signed [MV_W-1:0] MV_ONE = MV_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv_x <= '0;
         mv_y <= '0;
      end else if (init) begin
         mv_x <= MV_MIN;
         mv_y <= MV_MIN;
      end else if (step) begin
         if (mv_x == MV_MAX) begin
            mv_x <= MV_MIN;
            mv_y <= mv_y + MV_ONE;
         end else begin
            mv_x <= mv_x + MV_ONE;
         end
      end
   end

   assign last = (mv_x == MV_MAX) && (mv_y == MV_MAX);

endmodule
`default_nettype wire

// File: rtl/sad_best_match.sv
`default_nettype none
// ============================================================================
// Module : sad_best_match
// Brief  : Tracks minimum SAD and its MV over a raster search window.
//          Optional macro SAD_ZERO_MV_BIAS_EN credits ZERO_BIAS to MV (0,0).
// Rev    : 1.0  initial release
// ============================================================================
module sad_best_match
   import sad_search_pkg::*;
#(
   parameter int SAD_W     = SAD_W_DEF,
   parameter int RANGE     = 4,
   parameter int MV_W      = MV_W_DEF,
   parameter int ZERO_BIAS = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sad_valid,
   input  logic [SAD_W-1:0]       sad,
   output logic                   sad_ready,
   output logic                   busy,
   output logic                   done,
   output logic [SAD_W-1:0]       best_sad,
   output logic signed [MV_W-1:0] best_mv_x,
   output logic signed [MV_W-1:0] best_mv_y
);

   generate
      if (RANGE < 1 || (2 ** (MV_W - 1)) - 1 < RANGE || ZERO_BIAS < 0) begin : g_param_check
         $error("sad_best_match: illegal RANGE/MV_W/ZERO_BIAS combination");
      end
   endgenerate

   state_t                 state;
   state_t                 state_nxt;
   logic                   init;
   logic                   accept;
   logic                   last;
   logic signed [MV_W-1:0] mv_x;
   logic signed [MV_W-1:0] mv_y;
   logic [SAD_W-1:0]       eff_sad;
   logic [SAD_W-1:0]       min_sad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // start wins in every state: it aborts a search or chains after DONE.
   always_comb begin
      state_nxt = state;
      init      = start;
      accept    = 1'b0;
      sad_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = SEARCH;
         end
         SEARCH: begin
            sad_ready = 1'b1;
            busy      = 1'b1;
            accept    = sad_valid && !start;
            if (start)               state_nxt = SEARCH;
            else if (accept && last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? SEARCH : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   mv_raster_counter #(
      .RANGE (RANGE),
      .MV_W  (MV_W)
   ) u_raster (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (init),
      .step  (accept),
      .mv_x  (mv_x),
      .mv_y  (mv_y),
      .last  (last)
   );

`ifdef SAD_ZERO_MV_BIAS_EN
   localparam logic [SAD_W-1:0] BIAS = SAD_W'(ZERO_BIAS);
   logic at_origin;
   assign at_origin = (mv_x == '0) && (mv_y == '0);
   assign eff_sad   = !at_origin ? sad : ((sad > BIAS) ? (sad - BIAS) : '0);
`else
   assign eff_sad = sad;
`endif

   // min_sad holds the effective (possibly biased) value; best_sad stays raw.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_sad   <= '0;
         best_sad  <= '0;
         best_mv_x <= '0;
         best_mv_y <= '0;
      end else if (init) begin
         min_sad   <= '1;
         best_sad  <= '1;
         best_mv_x <= '0;
         best_mv_y <= '0;
      end else if (accept && (eff_sad < min_sad)) begin
         min_sad   <= eff_sad;
         best_sad  <= sad;
         best_mv_x <= mv_x;
         best_mv_y <= mv_y;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sad_best_match.sv
`default_nettype none
// ============================================================================
// Module : tb_sad_best_match
// Brief  : Randomized self-checking bench against a window-level reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sad_best_match;

   localparam int SAD_W = 12;
   localparam int RANGE = 4;
   localparam int MV_W  = 5;
   localparam int ZB    = 16;
   localparam int SIDE  = 2 * RANGE + 1;
   localparam int N     = SIDE * SIDE;
   localparam int ONES  = (1 << SAD_W) - 1;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic                   sad_valid = 1'b0;
   logic [SAD_W-1:0]       sad = '0;
   logic                   sad_ready;
   logic                   busy;
   logic                   done;
   logic [SAD_W-1:0]       best_sad;
   logic signed [MV_W-1:0] best_mv_x;
   logic signed [MV_W-1:0] best_mv_y;

   int n_chk = 0;
   int n_pass = 0;
   int done_cnt = 0;
   int sads[N];
   int exp_s, exp_x, exp_y;

   sad_best_match #(
      .SAD_W     (SAD_W),
      .RANGE     (RANGE),
      .MV_W      (MV_W),
      .ZERO_BIAS (ZB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sad_valid (sad_valid),
      .sad       (sad),
      .sad_ready (sad_ready),
      .busy      (busy),
      .done      (done),
      .best_sad  (best_sad),
      .best_mv_x (best_mv_x),
      .best_mv_y (best_mv_y)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Window index i -> (x,y) with x varying fastest.
   function automatic int eff(input int i);
`ifdef SAD_ZERO_MV_BIAS_EN
      if ((i % SIDE) - RANGE == 0 && (i / SIDE) - RANGE == 0)
         return (sads[i] > ZB) ? sads[i] - ZB : 0;
`endif
      return sads[i];
   endfunction

   task automatic model();
      int m;
      m     = ONES;
      exp_s = ONES;
      exp_x = 0;
      exp_y = 0;
      for (int i = 0; i < N; i++) begin
         if (eff(i) < m) begin
            m     = eff(i);
            exp_s = sads[i];
            exp_x = (i % SIDE) - RANGE;
            exp_y = (i / SIDE) - RANGE;
         end
      end
   endtask

   task automatic check_outputs(input string tag, input int s, input int x, input int y);
      chk({tag, "_sad"}, int'(best_sad), s);
      chk({tag, "_mvx"}, int'(best_mv_x), x);
      chk({tag, "_mvy"}, int'(best_mv_y), y);
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, int'(busy), 1);
      chk({tag, "_ready"}, int'(sad_ready), 1);
      chk({tag, "_init_sad"}, int'(best_sad), ONES);
   endtask

   task automatic feed(input int count, input int gap_pct);
      for (int i = 0; i < count; i++) begin
         for (int g = 0; g < 8 && int'($urandom_range(99)) < gap_pct; g++) begin
            sad_valid = 1'b0;
            sad       = SAD_W'($urandom);
            tick();
         end
         sad_valid = 1'b1;
         sad       = SAD_W'(sads[i]);
         tick();
         sad_valid = 1'b0;
      end
   endtask

   task automatic run_window(input string tag, input int gap_pct);
      int c0;
      model();
      c0 = done_cnt;
      do_start(tag);
      feed(N, gap_pct);
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_busy_at_done"}, int'(busy), 0);
      check_outputs(tag, exp_s, exp_x, exp_y);
      tick();
      chk({tag, "_done_drop"}, int'(done), 0);
      chk({tag, "_done_once"}, done_cnt - c0, 1);
      check_outputs({tag, "_hold"}, exp_s, exp_x, exp_y);
   endtask

   initial begin
      int c0;
      tick();
      tick();
      chk("rst_ready", int'(sad_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      check_outputs("rst", 0, 0, 0);
      rst_n = 1'b1;
      tick();

      // single clear minimum at (1,-2)
      for (int i = 0; i < N; i++) sads[i] = 500;
      sads[2 * SIDE + 5] = 37;
      run_window("single_min", 0);

      // all equal: first candidate keeps the win
      for (int i = 0; i < N; i++) sads[i] = 200;
      run_window("ties", 0);

      // gappy valids, minimum on the last candidate
      for (int i = 0; i < N; i++) sads[i] = int'($urandom_range(ONES, 11));
      sads[N - 1] = 10;
      run_window("gaps", 50);
      c0 = done_cnt;
      for (int k = 0; k < 6; k++) begin
         sad_valid = 1'b1;
         sad       = '0;
         tick();
      end
      sad_valid = 1'b0;
      tick();
      chk("idle_valid_done", done_cnt - c0, 0);
      chk("idle_valid_busy", int'(busy), 0);
      check_outputs("idle_valid", 10, RANGE, RANGE);

      // abort after 40 candidates, then a full window
      c0 = done_cnt;
      for (int i = 0; i < N; i++) sads[i] = int'($urandom_range(ONES, 6));
      sads[4] = 5;
      do_start("abort_a");
      feed(40, 0);
      for (int i = 0; i < N; i++) sads[i] = int'($urandom_range(ONES, 91));
      sads[6 * SIDE + 1] = 90;
      run_window("abort_b", 0);
      chk("abort_single_done", done_cnt - c0, 1);
      check_outputs("abort_exp", 90, -3, 2);

      // zero-MV credit scenario
      for (int i = 0; i < N; i++) sads[i] = 300;
      sads[(N - 1) / 2]  = 110;
      sads[5 * SIDE + 6] = 100;
      run_window("bias", 0);

      // asynchronous reset mid-search
      c0 = done_cnt;
      for (int i = 0; i < N; i++) sads[i] = int'($urandom_range(ONES, 0));
      do_start("rst_mid");
      feed(30, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", int'(sad_ready), 0);
      chk("rst_mid_busy", int'(busy), 0);
      check_outputs("rst_mid", 0, 0, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_mid_no_done", done_cnt - c0, 0);
      run_window("post_rst", 25);

      // all-ones: nothing beats the initial minimum
      for (int i = 0; i < N; i++) sads[i] = ONES;
      run_window("all_ones", 0);

      // small random values make frequent ties
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N; i++) sads[i] = int'($urandom_range(63, 0));
         run_window($sformatf("rand%0d", r), 30);
      end

      // start during the DONE cycle chains straight into a new search
      for (int i = 0; i < N; i++) sads[i] = int'($urandom_range(ONES, 0));
      model();
      do_start("chain_a");
      feed(N, 0);
      c0 = done_cnt;
      chk("chain_done", int'(done), 1);
      check_outputs("chain_a", exp_s, exp_x, exp_y);
      for (int i = 0; i < N; i++) sads[i] = int'($urandom_range(ONES, 0));
      model();
      do_start("chain_b");
      chk("chain_pulse", done_cnt - c0, 1);
      feed(N, 0);
      chk("chain_b_done", int'(done), 1);
      check_outputs("chain_b", exp_s, exp_x, exp_y);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
